hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the five-stage MIPS datapath. Generates the 2-bit forwarding selects that drive the Execute-stage 3-input operand muxes, the 1-bit Decode-stage branch-compare forwards, the load-use and branch stalls, and the flushes. A registered wait-state FSM freezes the pipeline while a slow data memory completes an access in Memory.

## Interface
- `WAIT_CYCLES`, default 2: data-memory wait states per load/store; 0 means single-cycle memory.
- `REG_AW`, default 5: register-address width.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rs_d`, `rt_d`  in  REG_AW  Decode source registers.
- `rs_e`, `rt_e`  in  REG_AW  Execute source registers.
- `write_reg_e`, `write_reg_m`, `write_reg_w`  in  REG_AW  destination register per stage.
- `reg_write_e`, `reg_write_m`, `reg_write_w`  in  1  register-write enable per stage.
- `mem_to_reg_e`, `mem_to_reg_m`  in  1  load in E / M.
- `mem_access_m`  in  1  load or store in M.
- `branch_d`  in  1  branch in D.
- `pc_src_d`  in  1  branch taken.
- `forward_a_e`, `forward_b_e`  out  2  Execute operand select.
- `forward_a_d`, `forward_b_d`  out  1  Decode compare select: 1 = ALUOutM.
- `stall_f`, `stall_d`, `stall_e`, `stall_m`  out  1  hold the stage register.
- `flush_d`, `flush_e`, `flush_w`  out  1  clear the stage register to a bubble.

## Operation
- **Forward encoding.** 00 = register file, 01 = ResultW, 10 = ALUOutM. The code 11 is never driven, because the downstream mux outputs zero for it.
- **forward_a_e.** 10 if `rs_e != 0 && reg_write_m && rs_e == write_reg_m`. Otherwise 01 if the same test passes against W. Otherwise 00. M has priority over W.
- **forward_b_e.** Same rule, using `rt_e`.
- **forward_a_d / forward_b_d.** 1 if `rs_d` / `rt_d` is non-zero, `reg_write_m` is set, and it equals `write_reg_m`.
- **lwstall.** `mem_to_reg_e && (rt_e == rs_d || rt_e == rt_d)`.
- **brstall.** `branch_d`, and either of:
  - `reg_write_e` with `write_reg_e` equal to `rs_d` or `rt_d`;
  - `mem_to_reg_m` with `write_reg_m` equal to `rs_d` or `rt_d`.
- **Wait FSM states.** IDLE, WAIT, DONE. Down-counter `cnt` has width `$clog2(WAIT_CYCLES+1)`, minimum 1.
  - IDLE, `mem_access_m`, and `WAIT_CYCLES >= 2`: go to WAIT, load `cnt = WAIT_CYCLES-1`.
  - IDLE, `mem_access_m`, and `WAIT_CYCLES == 1`: go to DONE.
  - WAIT with `cnt == 1`: go to DONE. Otherwise decrement `cnt`.
  - DONE: go to IDLE unconditionally. DONE never re-triggers on the same instruction.
- **mem_stall.** Asserted when in WAIT, or when in IDLE with `mem_access_m` and `WAIT_CYCLES > 0`. This gives exactly `WAIT_CYCLES` stall cycles per access.
- **Output priority, mem_stall = 1:** all four stall outputs = 1, `flush_w` = 1, `flush_e` = 0, `flush_d` = 0.
- **Output priority, otherwise:**
  - `stall_f = stall_d = flush_e = lwstall | brstall`;
  - `stall_e = stall_m = flush_w = 0`;
  - `flush_d = pc_src_d & ~stall_d`.
- Register 0 is never forwarded.

## Timing
- Forwarding, stall and flush outputs are combinational from the inputs and the FSM state, with zero-cycle latency.
- The FSM and `cnt` update on the rising edge of `clk`.
- Reset: state = IDLE, `cnt` = 0. There are no output registers. During and after reset, outputs equal the IDLE-state combinational function of the inputs.
- Reset asserted in WAIT: state returns to IDLE immediately. `mem_stall` drops unless `mem_access_m` is high.
- Back-to-back accesses: DONE, then IDLE, then re-trigger on the next instruction. Every access gets the full `WAIT_CYCLES` stall.
- `lwstall` or `brstall` coinciding with `mem_stall`: `mem_stall` wins. The load-use stall is re-evaluated once the pipeline moves.

## Configuration
- `HAZARD_MEM_WAIT_EN` defined: the wait FSM, counter and `mem_stall` are built as described.
- `HAZARD_MEM_WAIT_EN` undefined:
  - no FSM or counter registers;
  - `mem_stall` is tied to 0 and `mem_access_m` is ignored;
  - `stall_e`, `stall_m` and `flush_w` are constant 0;
  - `WAIT_CYCLES` has no effect.

## Structure
- Shared package `mips_pkg` holds:
  - `fwd_sel_t` enum: `FWD_RF` = 2'b00, `FWD_WB` = 2'b01, `FWD_MEM` = 2'b10;
  - `memwait_state_t` enum: IDLE, WAIT, DONE.
- Sub-module `mem_wait_ctrl` contains the FSM and counter, and outputs `mem_stall`. It is instantiated only under `HAZARD_MEM_WAIT_EN`.

## Test plan
- Arithmetic back-to-back forwarding: `rs_e` = 8, `write_reg_m` = 8, `reg_write_m` = 1, `write_reg_w` = 8, `reg_write_w` = 1 -> `forward_a_e` = 10. With `reg_write_m` = 0 -> 01. With `rs_e` = 0 -> 00.
- Load-use: `mem_to_reg_e` = 1, `rt_e` = 9, `rs_d` = 9 -> `stall_f` = `stall_d` = `flush_e` = 1 for one cycle, all other stall/flush outputs = 0.
- Branch hazard: `branch_d` = 1, `rs_d` = 4, `reg_write_e` = 1, `write_reg_e` = 4 -> stall. On the next cycle with `write_reg_m` = 4 and `reg_write_m` = 1 -> `forward_a_d` = 1. With `pc_src_d` = 1 -> `flush_d` = 1.
- Wait states: `WAIT_CYCLES` = 3, `mem_access_m` = 1 held -> `stall_m` = 1 for exactly 3 cycles, then 0 for one cycle (DONE). Two consecutive accesses -> 3 + 3 stalls separated by one free cycle.
- Reset mid-wait: `reset_n` = 0 during the second WAIT cycle with `mem_access_m` = 0 -> stalls drop immediately. After release, the next access gets the full 3-cycle stall.
- Macro undefined, `mem_access_m` = 1 -> `stall_m` and `flush_w` are always 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types for the MIPS pipeline hazard controller: forward-select codes
// and the data-memory wait-state FSM encoding.
package mips_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } memwait_state_t;

  localparam int NUM_SRC = 2;  // operand lanes A (rs) and B (rt)

  // Counter width for a down-counter reaching WAIT_CYCLES-1, never below 1 bit.
  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles < 2) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Hazard-unit bus: pipeline register/control taps in, forward/stall/flush out.
// The slave modport is the hazard unit; the master side drives the pipeline taps.
interface hazard_unit_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] rs_d, rt_d, rs_e, rt_e;
    logic [REG_AW-1:0] write_reg_e, write_reg_m, write_reg_w;
    logic              reg_write_e, reg_write_m, reg_write_w;
    logic              mem_to_reg_e, mem_to_reg_m, mem_access_m;
    logic              branch_d, pc_src_d;
    logic [1:0]        forward_a_e, forward_b_e;
    logic              forward_a_d, forward_b_d;
    logic              stall_f, stall_d, stall_e, stall_m;
    logic              flush_d, flush_e, flush_w;

    modport slave (
        input  rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
               reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m,
               mem_access_m, branch_d, pc_src_d,
        output forward_a_e, forward_b_e, forward_a_d, forward_b_d,
               stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w
    );

    modport master (
        output rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
               reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m,
               mem_access_m, branch_d, pc_src_d,
        input  forward_a_e, forward_b_e, forward_a_d, forward_b_d,
               stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w
    );
endinterface

// File: rtl/hazard_unit_mem_wait.sv
// Data-memory wait-state FSM: holds mem_stall for exactly WAIT_CYCLES cycles per
// access, then spends one DONE cycle so the same instruction cannot re-trigger.
module mem_wait_ctrl
    import mips_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic mem_access_m_i,
    output logic mem_stall_o
);
    localparam int CW = cnt_width(WAIT_CYCLES);

    memwait_state_t state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_stall_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_access_m_i && WAIT_CYCLES > 0) mem_stall_o = 1'b1;
                if (mem_access_m_i && WAIT_CYCLES >= 2) begin
                    state_d = WAIT;
                    cnt_d   = CW'(WAIT_CYCLES - 1);
                end else if (mem_access_m_i && WAIT_CYCLES == 1) begin
                    state_d = DONE;
                end
            end
            WAIT: begin
                mem_stall_o = 1'b1;
                if (cnt_q == CW'(1)) state_d = DONE;
                else                 cnt_d   = cnt_q - CW'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: rtl/hazard_unit.sv
// Five-stage MIPS hazard controller: forwarding selects, load-use/branch stalls,
// flushes. Define HAZARD_MEM_WAIT_EN to build the data-memory wait-state freeze.
module hazard_unit
    import mips_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int REG_AW      = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    hazard_unit_if.slave  hif
);
    logic [NUM_SRC-1:0][REG_AW-1:0] src_e, src_d;
    fwd_sel_t [NUM_SRC-1:0]         fwd_e;
    logic [NUM_SRC-1:0]             fwd_d;
    logic                           lwstall, brstall, hz_stall, mem_stall;

    assign src_e = {hif.rt_e, hif.rs_e};
    assign src_d = {hif.rt_d, hif.rs_d};

    // Memory stage wins over writeback; register 0 is hardwired and never forwarded.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            fwd_e[i] = FWD_RF;
            if (src_e[i] != '0 && hif.reg_write_m && src_e[i] == hif.write_reg_m)
                fwd_e[i] = FWD_MEM;
            else if (src_e[i] != '0 && hif.reg_write_w && src_e[i] == hif.write_reg_w)
                fwd_e[i] = FWD_WB;
            fwd_d[i] = (src_d[i] != '0) && hif.reg_write_m && (src_d[i] == hif.write_reg_m);
        end
    end

    assign hif.forward_a_e = fwd_e[0];
    assign hif.forward_b_e = fwd_e[1];
    assign hif.forward_a_d = fwd_d[0];
    assign hif.forward_b_d = fwd_d[1];

    assign lwstall = hif.mem_to_reg_e && (hif.rt_e == hif.rs_d || hif.rt_e == hif.rt_d);
    assign brstall = hif.branch_d &&
        ((hif.reg_write_e  && (hif.write_reg_e == hif.rs_d || hif.write_reg_e == hif.rt_d)) ||
         (hif.mem_to_reg_m && (hif.write_reg_m == hif.rs_d || hif.write_reg_m == hif.rt_d)));
    assign hz_stall = lwstall | brstall;

`ifdef HAZARD_MEM_WAIT_EN
    mem_wait_ctrl #(.WAIT_CYCLES(WAIT_CYCLES)) u_mem_wait (
        .clk            (clk),
        .reset_n        (reset_n),
        .mem_access_m_i (hif.mem_access_m),
        .mem_stall_o    (mem_stall)
    );
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, reset_n, hif.mem_access_m, WAIT_CYCLES[0]};
    assign mem_stall = 1'b0;
`endif

    // A memory freeze holds every stage and bubbles W; load-use/branch waits for it.
    always_comb begin
        hif.stall_f = hz_stall;
        hif.stall_d = hz_stall;
        hif.stall_e = 1'b0;
        hif.stall_m = 1'b0;
        hif.flush_e = hz_stall;
        hif.flush_w = 1'b0;
        hif.flush_d = hif.pc_src_d & ~hz_stall;
        if (mem_stall) begin
            hif.stall_f = 1'b1;
            hif.stall_d = 1'b1;
            hif.stall_e = 1'b1;
            hif.stall_m = 1'b1;
            hif.flush_e = 1'b0;
            hif.flush_w = 1'b1;
            hif.flush_d = 1'b0;
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (WAIT_CYCLES = 3); the wait-state
// scenarios follow whichever HAZARD_MEM_WAIT_EN build is compiled.
module tb_hazard_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  hazard_unit_if #(.REG_AW(5)) hif ();

  hazard_unit #(.WAIT_CYCLES(3), .REG_AW(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hif     (hif)
  );

  always #5 clk = ~clk;

  // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
  logic [6:0] ctl;
  assign ctl = {hif.stall_f, hif.stall_d, hif.stall_e, hif.stall_m,
                hif.flush_d, hif.flush_e, hif.flush_w};

  task automatic clear_inputs();
    hif.rs_d = '0; hif.rt_d = '0; hif.rs_e = '0; hif.rt_e = '0;
    hif.write_reg_e = '0; hif.write_reg_m = '0; hif.write_reg_w = '0;
    hif.reg_write_e = 1'b0; hif.reg_write_m = 1'b0; hif.reg_write_w = 1'b0;
    hif.mem_to_reg_e = 1'b0; hif.mem_to_reg_m = 1'b0; hif.mem_access_m = 1'b0;
    hif.branch_d = 1'b0; hif.pc_src_d = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    #2;
    n_checks++;
    if (ctl !== 7'b0000000) begin n_fail++; $display("FAIL reset_ctl: got %b exp %b", ctl, 7'b0000000); end
    n_checks++;
    if ({hif.forward_a_e, hif.forward_b_e, hif.forward_a_d, hif.forward_b_d} !== 6'b000000) begin
      n_fail++; $display("FAIL reset_fwd: got %b exp %b",
        {hif.forward_a_e, hif.forward_b_e, hif.forward_a_d, hif.forward_b_d}, 6'b000000);
    end
    // Outputs stay combinational while reset is held.
    hif.rs_e = 5'd8; hif.write_reg_m = 5'd8; hif.reg_write_m = 1'b1;
    #1;
    n_checks++;
    if (hif.forward_a_e !== 2'b10) begin n_fail++; $display("FAIL reset_comb_fwd: got %b exp %b", hif.forward_a_e, 2'b10); end
    clear_inputs();
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_forward();
    clear_inputs();
    hif.rs_e = 5'd8; hif.write_reg_m = 5'd8; hif.reg_write_m = 1'b1;
    hif.write_reg_w = 5'd8; hif.reg_write_w = 1'b1;
    #1;
    n_checks++;
    if (hif.forward_a_e !== 2'b10) begin n_fail++; $display("FAIL fwd_a_mem: got %b exp %b", hif.forward_a_e, 2'b10); end
    n_checks++;
    if (hif.forward_b_e !== 2'b00) begin n_fail++; $display("FAIL fwd_b_idle: got %b exp %b", hif.forward_b_e, 2'b00); end
    hif.reg_write_m = 1'b0; #1;
    n_checks++;
    if (hif.forward_a_e !== 2'b01) begin n_fail++; $display("FAIL fwd_a_wb: got %b exp %b", hif.forward_a_e, 2'b01); end
    hif.rs_e = 5'd0; #1;
    n_checks++;
    if (hif.forward_a_e !== 2'b00) begin n_fail++; $display("FAIL fwd_a_r0: got %b exp %b", hif.forward_a_e, 2'b00); end
    // r0 as a destination must not forward even with writes enabled.
    hif.write_reg_m = 5'd0; hif.write_reg_w = 5'd0; hif.reg_write_m = 1'b1; #1;
    n_checks++;
    if (hif.forward_a_e !== 2'b00) begin n_fail++; $display("FAIL fwd_a_r0_dest: got %b exp %b", hif.forward_a_e, 2'b00); end
    hif.rt_e = 5'd12; hif.write_reg_m = 5'd3; hif.write_reg_w = 5'd12; #1;
    n_checks++;
    if (hif.forward_b_e !== 2'b01) begin n_fail++; $display("FAIL fwd_b_wb: got %b exp %b", hif.forward_b_e, 2'b01); end
    hif.write_reg_m = 5'd12; #1;
    n_checks++;
    if (hif.forward_b_e !== 2'b10) begin n_fail++; $display("FAIL fwd_b_mem: got %b exp %b", hif.forward_b_e, 2'b10); end
    n_checks++;
    if (ctl !== 7'b0000000) begin n_fail++; $display("FAIL fwd_no_stall: got %b exp %b", ctl, 7'b0000000); end
  endtask

  task automatic test_load_use();
    clear_inputs();
    hif.mem_to_reg_e = 1'b1; hif.rt_e = 5'd9; hif.rs_d = 5'd9; #1;
    n_checks++;
    if (ctl !== 7'b1100010) begin n_fail++; $display("FAIL lw_rs: got %b exp %b", ctl, 7'b1100010); end
    hif.rs_d = 5'd1; hif.rt_d = 5'd9; hif.pc_src_d = 1'b1; #1;
    n_checks++;
    if (ctl !== 7'b1100010) begin n_fail++; $display("FAIL lw_rt_no_flushd: got %b exp %b", ctl, 7'b1100010); end
    hif.rt_d = 5'd2; hif.pc_src_d = 1'b0; #1;
    n_checks++;
    if (ctl !== 7'b0000000) begin n_fail++; $display("FAIL lw_nomatch: got %b exp %b", ctl, 7'b0000000); end
  endtask

  task automatic test_branch();
    clear_inputs();
    hif.branch_d = 1'b1; hif.rs_d = 5'd4; hif.reg_write_e = 1'b1; hif.write_reg_e = 5'd4; #1;
    n_checks++;
    if (ctl !== 7'b1100010) begin n_fail++; $display("FAIL br_stall_e: got %b exp %b", ctl, 7'b1100010); end
    @(posedge clk); #1;
    hif.reg_write_e = 1'b0; hif.write_reg_e = 5'd0;
    hif.write_reg_m = 5'd4; hif.reg_write_m = 1'b1; #1;
    n_checks++;
    if (hif.forward_a_d !== 1'b1) begin n_fail++; $display("FAIL br_fwd_a_d: got %b exp %b", hif.forward_a_d, 1'b1); end
    n_checks++;
    if (hif.forward_b_d !== 1'b0) begin n_fail++; $display("FAIL br_fwd_b_d: got %b exp %b", hif.forward_b_d, 1'b0); end
    hif.pc_src_d = 1'b1; #1;
    n_checks++;
    if (ctl !== 7'b0000100) begin n_fail++; $display("FAIL br_flush_d: got %b exp %b", ctl, 7'b0000100); end
    // Load result still in M: branch must wait.
    hif.mem_to_reg_m = 1'b1; hif.rs_d = 5'd7; hif.rt_d = 5'd4; #1;
    n_checks++;
    if (ctl !== 7'b1100010) begin n_fail++; $display("FAIL br_stall_m: got %b exp %b", ctl, 7'b1100010); end
    n_checks++;
    if ({hif.forward_a_d, hif.forward_b_d} !== 2'b01) begin
      n_fail++; $display("FAIL br_fwd_b_d2: got %b exp %b", {hif.forward_a_d, hif.forward_b_d}, 2'b01);
    end
  endtask

`ifdef HAZARD_MEM_WAIT_EN
  task automatic test_wait_states();
    logic [7:0] pat;
    logic       exp_s;
    pat = 8'b01110111;  // bit i = stall expected i cycles after the access arrives
    clear_inputs();
    // Coincident load-use: mem_stall must take priority.
    hif.mem_to_reg_e = 1'b1; hif.rt_e = 5'd9; hif.rs_d = 5'd9;
    hif.mem_access_m = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) begin @(posedge clk); #1; end
      exp_s = pat[i];
      n_checks++;
      if (ctl !== (exp_s ? 7'b1111001 : 7'b1100010)) begin
        n_fail++; $display("FAIL wait_cyc%0d: got %b exp %b", i, ctl, exp_s ? 7'b1111001 : 7'b1100010);
      end
    end
    clear_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_wait();
    clear_inputs();
    hif.mem_access_m = 1'b1; #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (hif.stall_m !== 1'b1) begin n_fail++; $display("FAIL rst_wait_pre: got %b exp %b", hif.stall_m, 1'b1); end
    hif.mem_access_m = 1'b0; reset_n = 1'b0; #1;
    n_checks++;
    if (ctl !== 7'b0000000) begin n_fail++; $display("FAIL rst_wait_drop: got %b exp %b", ctl, 7'b0000000); end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    hif.mem_access_m = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) begin @(posedge clk); #1; end
      n_checks++;
      if (hif.stall_m !== (i < 3)) begin
        n_fail++; $display("FAIL rst_wait_after%0d: got %b exp %b", i, hif.stall_m, (i < 3));
      end
    end
    clear_inputs();
    @(posedge clk); #1;
  endtask
`else
  task automatic test_wait_states();
    clear_inputs();
    hif.mem_access_m = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({hif.stall_e, hif.stall_m, hif.flush_w} !== 3'b000) begin
        n_fail++; $display("FAIL nowait_cyc%0d: got %b exp %b", i, {hif.stall_e, hif.stall_m, hif.flush_w}, 3'b000);
      end
    end
    hif.mem_to_reg_e = 1'b1; hif.rt_e = 5'd9; hif.rs_d = 5'd9; #1;
    n_checks++;
    if (ctl !== 7'b1100010) begin n_fail++; $display("FAIL nowait_lw: got %b exp %b", ctl, 7'b1100010); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_wait();
    clear_inputs();
    hif.mem_access_m = 1'b1; reset_n = 1'b0; #1;
    n_checks++;
    if (ctl !== 7'b0000000) begin n_fail++; $display("FAIL nowait_rst: got %b exp %b", ctl, 7'b0000000); end
    @(negedge clk); reset_n = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_wait_states();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
